fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that lets NREQ valid/ready requesters share the write
// port of one downstream FIFO. One requester at a time holds a grant and
// streams up to BURST words. The grant ends when the holder drops its valid
// or completes BURST beats, and the next search then starts just past it.
// Arbitration costs one idle cycle: the owner is registered in IDLE and data
// moves only in BURST.
//
// Parameters
//   NREQ   number of requesters (2..8)
//   NBITS  data word width
//   BURST  maximum beats per grant (1..15)
//
// Ports
//   clk        clock
//   rst        asynchronous, active-low reset
//   req_val    per-requester data valid
//   req_msg    per-requester data, requester i at [i*NBITS +: NBITS]
//   req_rdy    per-requester accept (only the owner, only when FIFO not full)
//   fifo_full  downstream FIFO full flag
//   fifo_wen   downstream FIFO write enable (combinational beat)
//   fifo_d     downstream FIFO write data, zero when fifo_wen is low
//   owner      index of the current grant holder
//   busy       high while a grant is held
//   stat_beats per-requester 16-bit saturating beat counters
//              (only when FIFO_WR_ARBITER_STATS_EN is defined)
//
// Optional feature macro: FIFO_WR_ARBITER_STATS_EN
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int NBITS = 16,
    parameter int BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_val,
    input  logic [NREQ*NBITS-1:0]     req_msg,
    output logic [NREQ-1:0]           req_rdy,
    input  logic                      fifo_full,
    output logic                      fifo_wen,
    output logic [NBITS-1:0]          fifo_d,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    output logic [NREQ*16-1:0]        stat_beats
`endif
);

    localparam int OW = $clog2(NREQ);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [3:0]      cnt_q, cnt_d;

    logic [OW-1:0]   pick;
    logic            found;
    logic [2*NREQ-1:0] val_dbl;
    logic [NREQ-1:0] val_rot;
    logic [OW:0]     pick_sum;
    logic [OW-1:0]   next_ptr;
    logic            own_val;
    logic [NBITS-1:0] own_msg;
    logic            beat;

    // Round-robin search: rotate req_val so rr_ptr sits at bit 0, take the
    // lowest set bit, then map the offset back to an absolute index.
    always_comb begin
        val_dbl  = {req_val, req_val};
        val_rot  = val_dbl[NREQ-1:0];
        pick     = '0;
        pick_sum = '0;
        found    = 1'b0;
        val_rot  = NREQ'(val_dbl >> rr_ptr_q);
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (val_rot[k]) begin
                found    = 1'b1;
                pick_sum = {1'b0, rr_ptr_q} + (OW+1)'(k);
            end
        end
        if (pick_sum >= (OW+1)'(NREQ)) begin
            pick = OW'(pick_sum - (OW+1)'(NREQ));
        end else begin
            pick = OW'(pick_sum);
        end
    end

    // Owner's valid and data, muxed with constant indices.
    always_comb begin
        own_val = 1'b0;
        own_msg = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == OW'(i)) begin
                own_val = req_val[i];
                own_msg = req_msg[i*NBITS +: NBITS];
            end
        end
    end

    assign next_ptr = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        req_rdy  = '0;
        busy     = (state_q == S_BURST);
        beat     = busy & own_val & ~fifo_full;
        fifo_wen = beat;
        fifo_d   = beat ? own_msg : '0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d = pick;
                    cnt_d   = '0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                for (int i = 0; i < NREQ; i++) begin
                    if (owner_q == OW'(i)) req_rdy[i] = ~fifo_full;
                end
                // A dropped valid forfeits the grant even while stalled.
                if (!own_val) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = next_ptr;
                end else if (beat) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == 4'(BURST)) begin
                        state_d  = S_IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign owner = owner_q;

`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [15:0] stat_q [NREQ];
    logic [15:0] stat_d [NREQ];

    // Counters stick at 0xFFFF rather than wrapping.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            stat_d[i] = stat_q[i];
            if (beat && owner_q == OW'(i) && stat_q[i] != 16'hFFFF) begin
                stat_d[i] = stat_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) stat_q[i] <= stat_d[i];
        end
    end

    always_comb begin
        stat_beats = '0;
        for (int i = 0; i < NREQ; i++) stat_beats[i*16 +: 16] = stat_q[i];
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int NBITS = 16;
    localparam int BURST = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_val;
    logic [NREQ*NBITS-1:0] req_msg;
    logic [NREQ-1:0]       req_rdy;
    logic                  fifo_full;
    logic                  fifo_wen;
    logic [NBITS-1:0]      fifo_d;
    logic [1:0]            owner;
    logic                  busy;
`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [NREQ*16-1:0]    stat_beats;
`endif

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .BURST(BURST)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_val   (req_val),
        .req_msg   (req_msg),
        .req_rdy   (req_rdy),
        .fifo_full (fifo_full),
        .fifo_wen  (fifo_wen),
        .fifo_d    (fifo_d),
        .owner     (owner),
`ifdef FIFO_WR_ARBITER_STATS_EN
        .stat_beats(stat_beats),
`endif
        .busy      (busy)
    );

    typedef struct {
        int cyc;
        int own;
        int data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc_n;
    int   rem  [NREQ];
    int   sent [NREQ];
    int   base [NREQ];
    int   full_lo, full_hi;
    logic busy_log [64];

    // Requester sources: requester i offers words base+sent while sent<rem.
    task automatic drive_src();
        for (int i = 0; i < NREQ; i++) begin
            req_val[i] = (sent[i] < rem[i]);
            req_msg[i*NBITS +: NBITS] = NBITS'(base[i] + sent[i]);
        end
        fifo_full = (cyc_n >= full_lo) && (cyc_n <= full_hi);
    endtask

    task automatic init_scn();
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0; sent[i] = 0; base[i] = 0;
        end
        full_lo = -1;
        full_hi = -1;
        cyc_n   = 0;
        sb.delete();
        for (int i = 0; i < 64; i++) busy_log[i] = 1'bx;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic push_beats(input int own, input int d0, input int n, input int c0);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.cyc = c0 + k; e.own = own; e.data = d0 + k;
            sb.push_back(e);
        end
    endtask

    // One clock: sample at negedge, score, then advance sources after posedge.
    task automatic cyc();
        logic [NREQ-1:0] fire;
        logic [NREQ-1:0] want_fire;
        exp_t e;
        @(negedge clk);
        if (cyc_n < 64) busy_log[cyc_n] = busy;
        fire      = req_val & req_rdy;
        want_fire = fifo_wen ? (4'b0001 << owner) : 4'b0000;
        checks++;
        if (fire !== want_fire) begin
            errors++;
            $display("FAIL handshake cyc=%0d fire=%b want=%b", cyc_n, fire, want_fire);
        end
        checks++;
        if (fifo_full && (fifo_wen !== 1'b0 || req_rdy !== '0)) begin
            errors++;
            $display("FAIL stall cyc=%0d wen=%b rdy=%b want 0/0", cyc_n, fifo_wen, req_rdy);
        end
        checks++;
        if (fifo_wen !== 1'b1 && fifo_d !== '0) begin
            errors++;
            $display("FAIL idle_data cyc=%0d d=%h want 0", cyc_n, fifo_d);
        end
        checks++;
        if (busy !== 1'b1 && req_rdy !== '0) begin
            errors++;
            $display("FAIL idle_rdy cyc=%0d rdy=%b want 0", cyc_n, req_rdy);
        end
        if (fifo_wen === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL extra_beat cyc=%0d d=%h own=%0d want none", cyc_n, fifo_d, owner);
            end else begin
                e = sb.pop_front();
                if (int'(fifo_d) != e.data || int'(owner) != e.own || cyc_n != e.cyc) begin
                    errors++;
                    $display("FAIL beat got d=%h own=%0d cyc=%0d want d=%h own=%0d cyc=%0d",
                             fifo_d, owner, cyc_n, e.data[15:0], e.own, e.cyc);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) if (fire[i]) sent[i]++;
        cyc_n++;
        drive_src();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic end_scn(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_missing left=%0d want 0", name, sb.size());
        end
    endtask

    task automatic check_busy(input string name, input int c, input logic want);
        checks++;
        if (busy_log[c] !== want) begin
            errors++;
            $display("FAIL %s_busy cyc=%0d got=%b want=%b", name, c, busy_log[c], want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_val = '1;
        req_msg = '1;
        fifo_full = 1'b0;
        #3;
        checks++;
        if (busy !== 1'b0 || fifo_wen !== 1'b0 || fifo_d !== '0 || req_rdy !== '0 || owner !== '0) begin
            errors++;
            $display("FAIL reset busy=%b wen=%b d=%h rdy=%b own=%0d want all 0",
                     busy, fifo_wen, fifo_d, req_rdy, owner);
        end
    endtask

    task automatic test_idle();
        apply_reset();
        init_scn();
        drive_src();
        run(4);
        for (int c = 0; c < 4; c++) check_busy("idle", c, 1'b0);
        end_scn("idle");
    endtask

    task automatic test_single();
        apply_reset();
        init_scn();
        rem[2] = 6; base[2] = 'hA0;
        drive_src();
        push_beats(2, 'hA0, 4, 1);
        push_beats(2, 'hA4, 2, 6);
        run(10);
        check_busy("single", 0, 1'b0);
        check_busy("single", 5, 1'b0);
        end_scn("single");
    endtask

    task automatic test_round_robin();
        apply_reset();
        init_scn();
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 100; base[i] = i << 8;
        end
        drive_src();
        push_beats(0, 'h000, 4, 1);
        push_beats(1, 'h100, 4, 6);
        push_beats(2, 'h200, 4, 11);
        push_beats(3, 'h300, 4, 16);
        push_beats(0, 'h004, 4, 21);
        run(25);
        end_scn("round_robin");
    endtask

    task automatic test_backpressure();
        apply_reset();
        init_scn();
        rem[0] = 6; base[0] = 'hC0;
        full_lo = 3; full_hi = 5;
        drive_src();
        push_beats(0, 'hC0, 2, 1);
        push_beats(0, 'hC2, 2, 6);
        push_beats(0, 'hC4, 2, 9);
        run(12);
        for (int c = 3; c <= 5; c++) check_busy("stall", c, 1'b1);
        check_busy("stall", 8, 1'b0);
        end_scn("backpressure");
    endtask

    task automatic test_early_release();
        apply_reset();
        init_scn();
        rem[1] = 2; base[1] = 'h110;
        rem[3] = 4; base[3] = 'h330;
        drive_src();
        push_beats(1, 'h110, 2, 1);
        push_beats(3, 'h330, 4, 5);
        run(10);
        check_busy("release", 3, 1'b1);
        check_busy("release", 4, 1'b0);
        end_scn("early_release");
    endtask

    task automatic test_async_reset();
        apply_reset();
        init_scn();
        rem[0] = 100; base[0] = 'h000;
        rem[2] = 100; base[2] = 'h200;
        drive_src();
        push_beats(0, 'h000, 4, 1);
        push_beats(2, 'h200, 2, 6);
        run(8);
        #2;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_busy got=%b want=1", busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || fifo_wen !== 1'b0 || req_rdy !== '0 || fifo_d !== '0 || owner !== '0) begin
            errors++;
            $display("FAIL async_reset busy=%b wen=%b rdy=%b d=%h own=%0d want all 0",
                     busy, fifo_wen, req_rdy, fifo_d, owner);
        end
        end_scn("pre_reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        cyc_n = 0;
        drive_src();
        // Pointer must restart at 0, so requester 0 wins before requester 2.
        push_beats(0, 'h004, 4, 1);
        push_beats(2, 'h202, 4, 6);
        run(10);
        end_scn("post_reset");
    endtask

`ifdef FIFO_WR_ARBITER_STATS_EN
    task automatic test_stats();
        int beats = 0;
        int n = 0;
        apply_reset();
        init_scn();
        req_val = 4'b0001;
        req_msg = '0;
        fifo_full = 1'b0;
        // Enough beats to run well past 0xFFFF.
        while (beats < 66000 && n < 90000) begin
            @(negedge clk);
            if (fifo_wen === 1'b1) beats++;
            n++;
        end
        checks++;
        if (beats < 66000) begin
            errors++;
            $display("FAIL stats_timeout beats=%0d want 66000", beats);
        end
        checks++;
        if (stat_beats[15:0] !== 16'hFFFF) begin
            errors++;
            $display("FAIL stats_sat got=%h want ffff", stat_beats[15:0]);
        end
        checks++;
        if (stat_beats[NREQ*16-1:16] !== '0) begin
            errors++;
            $display("FAIL stats_others got=%h want 0", stat_beats[NREQ*16-1:16]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_round_robin();
        test_backpressure();
        test_early_release();
        test_async_reset();
`ifdef FIFO_WR_ARBITER_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
